// File: rtl/gb_timer_pkg.sv
// Shared timer definitions: I/O register addresses, TAC clock-select codes
// and the interrupt line index used by the interrupt controller.
package gb_timer_pkg;

  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;

  localparam int TIMER_INT = 2;

  // TAC[1:0] picks which system-counter bit clocks TIMA
  typedef enum logic [1:0] {
    SEL_BIT9 = 2'b00,
    SEL_BIT3 = 2'b01,
    SEL_BIT5 = 2'b10,
    SEL_BIT7 = 2'b11
  } tac_sel_e;

endpackage

// File: rtl/gb_timer_edge.sv
// Selects the TAC-chosen system-counter bit, gates it with the enable bit and
// emits a one-clock inc pulse on its falling edge. Inputs are the next-state
// counter and TAC so that DIV writes and TAC changes produce the same
// spurious increments as the original hardware.
module gb_timer_edge
  import gb_timer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  tac,
  input  logic [15:0] cnt,
  output logic        inc
);

  logic sel_bit;
  logic sig;
  logic sig_prev;

  // bit-select mux driven by the clock-select field
  always_comb begin
    sel_bit = cnt[9];
    case (tac_sel_e'(tac[1:0]))
      SEL_BIT9: sel_bit = cnt[9];
      SEL_BIT3: sel_bit = cnt[3];
      SEL_BIT5: sel_bit = cnt[5];
      SEL_BIT7: sel_bit = cnt[7];
      default:  sel_bit = cnt[9];
    endcase
  end

  assign sig = tac[2] & sel_bit;
  assign inc = sig_prev & ~sig;

  // history of the gated bit, updated every clock regardless of tick
  always_ff @(posedge clock) begin
    if (reset) sig_prev <= 1'b0;
    else       sig_prev <= sig;
  end

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer built on a free-running 16-bit system counter.
// TIMA overflow reloads TMA on the same edge and raises a sticky int_req.
module gb_timer
  import gb_timer_pkg::*;
#(
  parameter int CLK_PER_TICK = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        cs,
  output logic        int_req,
  input  logic        int_ack
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

  logic [PW-1:0] presc, presc_next;
  logic [15:0]   cnt, cnt_next;
  logic [7:0]    tima, tma, tma_eff;
  logic [2:0]    tac, tac_next;
  logic          tick, inc, ovf;
  logic          wr_en, wr_div, wr_tima, wr_tma, wr_tac;
  logic          unused_rd;

  // reads have no side effects, so the read strobe carries no information
  assign unused_rd = rd_n;

  assign wr_en   = cs & ~wr_n;
  assign wr_div  = wr_en & (A == ADDR_DIV);
  assign wr_tima = wr_en & (A == ADDR_TIMA);
  assign wr_tma  = wr_en & (A == ADDR_TMA);
  assign wr_tac  = wr_en & (A == ADDR_TAC);

  assign tick     = (presc == PW'(CLK_PER_TICK - 1));
  assign tac_next = wr_tac ? Di[2:0] : tac;
  assign tma_eff  = wr_tma ? Di : tma;
  assign ovf      = inc & ~wr_tima & (tima == 8'hFF);

  // next-state prescaler and system counter; a DIV write clears both
  always_comb begin
    presc_next = tick ? '0 : presc + PW'(1);
    cnt_next   = tick ? cnt + 16'd1 : cnt;
    if (wr_div) begin
      presc_next = '0;
      cnt_next   = '0;
    end
  end

  gb_timer_edge u_edge (
    .clock (clock),
    .reset (reset),
    .tac   (tac_next),
    .cnt   (cnt_next),
    .inc   (inc)
  );

  // register state: counter, TAC/TMA, TIMA with reload, sticky interrupt
  always_ff @(posedge clock) begin
    if (reset) begin
      presc   <= '0;
      cnt     <= '0;
      tac     <= '0;
      tma     <= '0;
      tima    <= '0;
      int_req <= 1'b0;
    end else begin
      presc <= presc_next;
      cnt   <= cnt_next;
      tac   <= tac_next;
      if (wr_tma) tma <= Di;
      if (wr_tima)  tima <= Di;
      else if (ovf) tima <= tma_eff;
      else if (inc) tima <= tima + 8'd1;
      if (ovf)          int_req <= 1'b1;
      else if (int_ack) int_req <= 1'b0;
    end
  end

  // combinational read mux
  always_comb begin
    Do = 8'hFF;
    if (cs) begin
      case (A)
        ADDR_DIV:  Do = cnt[15:8];
        ADDR_TIMA: Do = tima;
        ADDR_TMA:  Do = tma;
        ADDR_TAC:  Do = {5'b11111, tac};
        default:   Do = 8'hFF;
      endcase
    end
  end

endmodule
